// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - multi-channel runtime-programmable clock divider with tick and square-wave outputs
module prog_clock_divider #(
    parameter int WIDTH       = 26,
    parameter int N_CH        = 2,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  clr,
    input  logic [N_CH-1:0]  load,
    input  logic [WIDTH-1:0] div_value,
    output logic [N_CH-1:0]  slow_clk,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending
);

    // Periods below 2 cannot produce a distinct high and low phase, so they are raised to 2.
    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(2);
    localparam logic [WIDTH-1:0] DEF_P = (DEFAULT_DIV < 2) ? MIN_P : WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] load_p;

    // Clamped copy of the shared period input, used by every channel.
    always_comb begin
        load_p = (div_value < MIN_P) ? MIN_P : div_value;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt, cnt_n;
        logic [WIDTH-1:0] div_reg, div_n;
        logic [WIDTH-1:0] pend_reg, pend_reg_n;
        logic [WIDTH-1:0] thresh;
        logic             pend_q, pend_n;
        logic             slow_q, slow_n;
        logic             tick_q, tick_n;
        logic             wrap, idle, apply;

        // Next-state: clear beats counting beats hold; a new period only lands on a safe edge.
        always_comb begin
            cnt_n      = cnt;
            div_n      = div_reg;
            pend_reg_n = pend_reg;
            pend_n     = pend_q;
            slow_n     = slow_q;
            tick_n     = 1'b0;
            wrap       = en[i] && !clr[i] && (cnt == div_reg - WIDTH'(1));
            idle       = !en[i] && !clr[i] && (cnt == '0);
            apply      = clr[i] || wrap || (idle && load[i]);
            // High phase starts once the count reaches ceil(P/2).
            thresh     = div_reg - (div_reg >> 1);

            if (clr[i]) begin
                cnt_n  = '0;
                slow_n = 1'b0;
            end else if (en[i]) begin
                if (wrap) begin
                    cnt_n  = '0;
                    tick_n = 1'b1;
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                end
                slow_n = (cnt_n >= thresh);
            end

            if (load[i] && apply) begin
                div_n  = load_p;
                pend_n = 1'b0;
            end else if (load[i]) begin
                pend_reg_n = load_p;
                pend_n     = 1'b1;
            end else if (apply && pend_q) begin
                div_n  = pend_reg;
                pend_n = 1'b0;
            end
        end

        // Channel state register; reset discards any pending period.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt      <= '0;
                div_reg  <= DEF_P;
                pend_reg <= DEF_P;
                pend_q   <= 1'b0;
                slow_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt      <= cnt_n;
                div_reg  <= div_n;
                pend_reg <= pend_reg_n;
                pend_q   <= pend_n;
                slow_q   <= slow_n;
                tick_q   <= tick_n;
            end
        end

        assign slow_clk[i] = slow_q;
        assign tick[i]     = tick_q;
        assign pending[i]  = pend_q;
    end

endmodule
